// File: rtl/e_pkg.sv
// Shared defaults and helpers for the round-robin arbiter slice.
package e_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 32;

  typedef logic [$clog2(DEF_N)-1:0] id_t;

  // Advance the priority pointer past the winner. The wrap is explicit so a
  // non-power-of-two requester count never lets the pointer reach N.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/e_pick.sv
// Find-first-set over N bits, built as a ripple of priority cells.
// Each cell passes "someone below already won" upward and claims the grant
// only if it is valid and nothing below it was.
module e_pick
  import e_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] vld,
  output logic [N-1:0] onehot,
  output logic         any
);

  logic [N:0] prior;

  assign prior[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign onehot[i]  = vld[i] & ~prior[i];
    assign prior[i+1] = prior[i] | vld[i];
  end

  assign any = prior[N];

endmodule

// File: rtl/e_rr_arb.sv
// Round-robin arbiter: merges N valid/ready producers onto one registered
// output slot with one-cycle latency and full throughput.
module e_rr_arb
  import e_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_vld_i,
  input  logic [N*W-1:0] req_dat_i,
  output logic [N-1:0]   req_rdy_o,
  output logic           out_vld_o,
  output logic [W-1:0]   out_dat_o,
  output logic [IDW-1:0] out_id_o,
  input  logic           out_rdy_i
);

  logic [IDW-1:0] ptr;
  logic [N-1:0]   ptr_mask;
  logic [N-1:0]   m_oh;
  logic [N-1:0]   u_oh;
  logic           m_any;
  logic           u_any;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_id;
  logic [W-1:0]   win_dat;
  logic           slot_open;
  logic           xfer;

  // Requesters at or above the pointer get first pick this round.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ptr_mask = '0;
    for (int i = 0; i < N; i++) begin
      ptr_mask[i] = (i >= int'(ptr));
    end
  end

  e_pick #(.N(N)) u_pick_masked (
    .vld    (req_vld_i & ptr_mask),
    .onehot (m_oh),
    .any    (m_any)
  );

  e_pick #(.N(N)) u_pick_all (
    .vld    (req_vld_i),
    .onehot (u_oh),
    .any    (u_any)
  );

  // Fall back to the unmasked search only when nobody at/above ptr is valid.
  assign win_oh    = m_any ? m_oh : u_oh;
  assign slot_open = ~out_vld_o | out_rdy_i;
  assign req_rdy_o = (rst_n && slot_open && u_any) ? win_oh : '0;
  assign xfer      = |(req_vld_i & req_rdy_o);

  // One-hot to index: OR of indices is exact because at most one bit is set.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) win_id = win_id | IDW'(i);
    end
  end

  // AND-OR payload mux; the select comes only from valid bits, never data.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N; i++) begin
      win_dat = win_dat | (req_dat_i[i*W +: W] & {W{win_oh[i]}});
    end
  end

  // Output slot and priority pointer; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (!rst_n) begin
      out_vld_o <= 1'b0;
      out_dat_o <= '0;
      out_id_o  <= '0;
      ptr       <= '0;
    end else if (slot_open) begin
      if (xfer) begin
        out_vld_o <= 1'b1;
        out_dat_o <= win_dat;
        out_id_o  <= win_id;
        ptr       <= IDW'(wrap_inc(32'(win_id), 32'(N)));
      end else begin
        out_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_e_rr_arb.sv
// Self-checking bench for e_rr_arb: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// rotating-search reference model.
module tb_e_rr_arb;

  localparam int N   = 8;
  localparam int W   = 32;
  localparam int IDW = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_vld_i;
  logic [N*W-1:0] req_dat_i;
  logic [N-1:0]   req_rdy_o;
  logic           out_vld_o;
  logic [W-1:0]   out_dat_o;
  logic [IDW-1:0] out_id_o;
  logic           out_rdy_i;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // Reference model state.
  bit          m_vld;
  logic [W-1:0] m_dat;
  int          m_id;
  int          m_ptr;

  e_rr_arb #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld_i (req_vld_i),
    .req_dat_i (req_dat_i),
    .req_rdy_o (req_rdy_o),
    .out_vld_o (out_vld_o),
    .out_dat_o (out_dat_o),
    .out_id_o  (out_id_o),
    .out_rdy_i (out_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Round-robin search: walk from ptr upward with wrap, first valid wins.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_vld_i[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_rdy();
    int w;
    logic [N-1:0] r;
    r = '0;
    if (rst_n !== 1'b1) return r;
    if (m_vld && !out_rdy_i) return r;
    w = model_winner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Model advances on every rising edge from the inputs held across it.
  always @(posedge clk) begin
    int w;
    if (rst_n !== 1'b1) begin
      m_vld = 1'b0;
      m_dat = '0;
      m_id  = 0;
      m_ptr = 0;
    end else if (!m_vld || out_rdy_i) begin
      w = model_winner();
      if (w >= 0) begin
        m_vld = 1'b1;
        m_dat = req_dat_i[w*W +: W];
        m_id  = w;
        m_ptr = (w + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
  end

  // Compare process, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_out_vld", 64'(out_vld_o), 64'(m_vld));
      check("mon_out_dat", 64'(out_dat_o), 64'(m_dat));
      check("mon_out_id",  64'(out_id_o),  64'(m_id));
      check("mon_req_rdy", 64'(req_rdy_o), 64'(model_rdy()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dat_seq();
    for (int i = 0; i < N; i++) req_dat_i[i*W +: W] = W'(32'h100 + i);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_vld_i = '1;
    out_rdy_i = 1'b1;
    set_dat_seq();

    // Reset held two cycles with every requester valid.
    cyc();
    cyc();
    check("rst_out_vld", 64'(out_vld_o), 64'd0);
    check("rst_out_id",  64'(out_id_o),  64'd0);
    check("rst_out_dat", 64'(out_dat_o), 64'd0);
    check("rst_req_rdy", 64'(req_rdy_o), 64'd0);
    mon_en = 1'b1;

    // Full rotation: ids 0..7 then 0 again, one per cycle.
    rst_n = 1'b1;
    for (int k = 0; k <= N; k++) begin
      cyc();
      check("rot_vld", 64'(out_vld_o), 64'd1);
      check("rot_id",  64'(out_id_o),  64'(k % N));
      check("rot_dat", 64'(out_dat_o), 64'(32'h100 + (k % N)));
    end

    // Backpressure: grant 3, then stall five cycles with everyone valid.
    req_vld_i = 8'b0000_1000;
    cyc();
    check("bp_grant_id", 64'(out_id_o), 64'd3);
    req_vld_i = '1;
    out_rdy_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy_zero", 64'(req_rdy_o), 64'd0);
      cyc();
      check("bp_hold_vld", 64'(out_vld_o), 64'd1);
      check("bp_hold_id",  64'(out_id_o),  64'd3);
      check("bp_hold_dat", 64'(out_dat_o), 64'h103);
    end
    out_rdy_i = 1'b1;
    #1;
    check("bp_release_rdy", 64'(req_rdy_o), 64'h10);
    cyc();
    check("bp_release_id", 64'(out_id_o), 64'd4);

    // Wrap: move ptr to 6, then only requesters 1 and 2 valid.
    req_vld_i = 8'b0010_0000;
    cyc();
    check("wrap_pre_id", 64'(out_id_o), 64'd5);
    req_vld_i = 8'b0000_0110;
    #1;
    check("wrap_rdy1", 64'(req_rdy_o), 64'h02);
    cyc();
    check("wrap_id1", 64'(out_id_o), 64'd1);
    #1;
    check("wrap_rdy2", 64'(req_rdy_o), 64'h04);
    cyc();
    check("wrap_id2", 64'(out_id_o), 64'd2);

    // Sparse/withdraw: requester 5 valid for one cycle only.
    req_vld_i = 8'b0010_0000;
    cyc();
    check("sparse_id",  64'(out_id_o),  64'd5);
    check("sparse_vld", 64'(out_vld_o), 64'd1);
    req_vld_i = '0;
    cyc();
    check("sparse_drain_vld", 64'(out_vld_o), 64'd0);
    check("sparse_hold_id",   64'(out_id_o),  64'd5);
    req_vld_i = '1;
    #1;
    check("sparse_ptr6_rdy", 64'(req_rdy_o), 64'h40);

    // Reset mid-stream with the slot full and stalled.
    cyc();
    check("mid_pre_id", 64'(out_id_o), 64'd6);
    out_rdy_i = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_rdy", 64'(req_rdy_o), 64'd0);
    cyc();
    check("mid_rst_vld", 64'(out_vld_o), 64'd0);
    check("mid_rst_id",  64'(out_id_o),  64'd0);
    rst_n     = 1'b1;
    out_rdy_i = 1'b1;
    req_vld_i = 8'b0100_1000;
    #1;
    check("mid_first_rdy", 64'(req_rdy_o), 64'h08);
    cyc();
    check("mid_first_id", 64'(out_id_o), 64'd3);

    // Randomized traffic, including occasional resets and stalls.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 99) != 0);
      out_rdy_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       req_vld_i = N'($urandom);
        1:       req_vld_i = N'($urandom & $urandom & $urandom);
        default: req_vld_i = '1;
      endcase
      for (int i = 0; i < N; i++) req_dat_i[i*W +: W] = W'($urandom);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
